rr_arbiter_enc: RTL and testbench
=================================

Name: rr_arbiter_enc

Overview:
- Round-robin arbiter. Takes a request vector and emits a registered binary grant index with a valid/ready handshake.
- Sits directly upstream of the one-hot decoder. The decoder turns gnt_idx_o back into per-requester select lines for muxes and acknowledge fan-out.
- Fairness comes from a rotating priority pointer that advances past each accepted grant.

Parameters:
- REQ_NUM, 8, number of requesters; legal range 2..256, need not be a power of two.
- IDX_W, $clog2(REQ_NUM), width of the grant index; derived, never overridden.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_i  input  REQ_NUM  request vector; bit n = requester n wants service; level-sensitive.
- gnt_valid_o  output  1  a grant is presented on gnt_idx_o.
- gnt_ready_i  input  1  downstream accepts the grant; handshake = gnt_valid_o & gnt_ready_i.
- gnt_idx_o  output  IDX_W  binary index of the granted requester.

Behaviour:
- Reset: asserting rst clears state asynchronously.
  - gnt_valid_o=0, gnt_idx_o=0, internal pointer ptr=0.
  - Reset mid-grant discards the pending grant, with no handshake.
  - First arbitration happens on the first rising clk edge after rst deasserts.
- Arbitration (combinational pick):
  - Search req_i from bit ptr upward, wrapping from REQ_NUM-1 to 0.
  - Pick the first set bit. If no bit is set, there is no candidate.
- The output register loads when it is free: gnt_valid_o==0, or a handshake occurs this cycle.
  - If a candidate exists: gnt_valid_o<=1 and gnt_idx_o<=candidate.
  - Otherwise gnt_valid_o<=0 and gnt_idx_o holds its old value.
- Latency: 1 cycle from req_i asserted (output free) to gnt_valid_o asserted.
- Hold rule: while gnt_valid_o=1 and gnt_ready_i=0, gnt_idx_o and gnt_valid_o are frozen.
  - The grant does not withdraw even if the granted requester drops its req.
  - The grant is not pre-empted by a higher-priority request.
- Pointer update, on handshake only:
  - ptr <= gnt_idx_o+1, wrapping to 0 when gnt_idx_o==REQ_NUM-1 (non-power-of-two wrap is explicit, not by overflow).
  - No handshake leaves ptr unchanged.
- Back-to-back: in a handshake cycle, the pick for the next grant uses the updated ptr value (gnt_idx_o+1), not the old ptr.
  - Throughput is one grant per cycle when gnt_ready_i is held high.
  - A requester that holds req high gets at most one grant per rotation while others are requesting.
- Single requester: a continuously asserted lone req n is re-granted every cycle with ready=1.
- gnt_ready_i while gnt_valid_o=0 is ignored.
- Index range: gnt_idx_o is always < REQ_NUM; indices >= REQ_NUM are never produced.
- No X propagation: req_i bits are only sampled through the pick; state has defined reset values.

Optional Feature:
- Macro: RR_ARBITER_ENC_ONEHOT_OUT_EN.
- Defined: adds output port gnt_onehot_o [REQ_NUM-1:0].
  - Driven by an internal onehot_decoder instance (INPUT_W=IDX_W, OUTPUT_W=REQ_NUM) fed from gnt_idx_o, ANDed with gnt_valid_o.
  - All zeros when no grant is valid; adds no latency.
- Undefined: the port and the instance do not exist. Behaviour of all other ports is identical in both builds.

Decomposition:
- Package rr_arbiter_pkg holds:
  - the index-width helper function (clog2 with minimum 1);
  - the pointer-wrap increment function (idx, REQ_NUM) -> next idx.
- One natural sub-module: rr_priority_pick, purely combinational.
  - Inputs: req vector and ptr. Outputs: found flag and candidate index.
  - Implemented as double-width masked priority search.
- The top holds the output register, ptr and the handshake logic.

Test Plan:
- Reset: hold rst=1 with req_i=8'hFF -> gnt_valid_o=0, gnt_idx_o=0. Release rst -> the next edge yields valid=1, idx=0.
- Rotation: req_i=8'b1010_0101 with ready=1 constantly -> idx sequence 0,2,5,7,0,2… with one grant per cycle; ptr wraps from 7 to 0.
- Backpressure: grant idx=3 presented, ready=0 for 4 cycles while req[3] drops and req[1] rises -> idx stays 3 and valid stays 1. Ready=1 -> next grant idx=1 on the following cycle.
- Idle/empty: req_i=0 -> valid=0 for all cycles. A single-cycle pulse req[6] -> exactly one grant with idx=6, which completes when ready=1.
- Non-power-of-two: REQ_NUM=5, req_i=5'b11111, ready=1 -> idx 0,1,2,3,4,0; never 5..7.
- Async reset mid-operation: assert rst between edges while valid=1, idx=4 -> valid drops immediately without a clock edge. After release, arbitration restarts from ptr=0.
- With RR_ARBITER_ENC_ONEHOT_OUT_EN defined:
  - idx=5, valid=1 -> gnt_onehot_o=8'b0010_0000.
  - valid=0 -> gnt_onehot_o=0.

Source files
------------

// File: rtl/rr_arbiter_pkg.sv
// Shared helpers for the round-robin grant-index arbiter.
package rr_arbiter_pkg;

  // Index width for n entries, never less than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

  // Next index after idx, wrapping explicitly at req_num (need not be a power of two).
  function automatic int unsigned ptr_wrap_inc(input int unsigned idx, input int unsigned req_num);
    return (idx >= req_num - 32'd1) ? 32'd0 : idx + 32'd1;
  endfunction

endpackage

// File: rtl/onehot_decoder.sv
// Binary index to one-hot select lines.
module onehot_decoder #(
  parameter int unsigned INPUT_W  = 3,
  parameter int unsigned OUTPUT_W = 8
) (
  input  logic [INPUT_W-1:0]  in_i,
  output logic [OUTPUT_W-1:0] out_o
);

  always_comb begin
    out_o = '0;
    for (int i = 0; i < OUTPUT_W; i++) begin
      out_o[i] = (in_i == INPUT_W'(i));
    end
  end

endmodule

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
module rr_priority_pick
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM = 8,
  parameter int unsigned IDX_W   = idx_width(REQ_NUM)
) (
  input  logic [REQ_NUM-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               found_c_o,
  output logic [IDX_W-1:0]   idx_c_o
);

  localparam int unsigned DBL_W = 2 * REQ_NUM;
  localparam int unsigned POS_W = idx_width(DBL_W);

  logic [DBL_W-1:0] masked_c;
  logic [POS_W-1:0] pos_c;

  // Lower copy is masked below ptr; the upper copy supplies the wrapped-around bits.
  always_comb begin
    masked_c  = {req_i, req_i};
    found_c_o = 1'b0;
    pos_c     = '0;
    for (int i = 0; i < DBL_W; i++) begin
      if (POS_W'(i) < POS_W'(ptr_i)) masked_c[i] = 1'b0;
    end
    for (int i = DBL_W - 1; i >= 0; i--) begin
      if (masked_c[i]) begin
        found_c_o = 1'b1;
        pos_c     = POS_W'(i);
      end
    end
    idx_c_o = (pos_c >= POS_W'(REQ_NUM)) ? IDX_W'(pos_c - POS_W'(REQ_NUM)) : IDX_W'(pos_c);
  end

endmodule

// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter with registered binary grant index and valid/ready handshake.
// Define RR_ARBITER_ENC_ONEHOT_OUT_EN to add the decoded gnt_onehot_o output.
module rr_arbiter_enc
  import rr_arbiter_pkg::*;
#(
  parameter int unsigned REQ_NUM = 8,
  parameter int unsigned IDX_W   = idx_width(REQ_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [REQ_NUM-1:0] req_i,
  output logic               gnt_valid_o,
  input  logic               gnt_ready_i,
  output logic [IDX_W-1:0]   gnt_idx_o
`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
  ,
  output logic [REQ_NUM-1:0] gnt_onehot_o
`endif
);

  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic             handshake_c;
  logic             load_c;
  logic [IDX_W-1:0] ptr_inc_c;
  logic [IDX_W-1:0] pick_ptr_c;
  logic             found_c;
  logic [IDX_W-1:0] cand_idx_c;

  assign handshake_c = gnt_valid_q & gnt_ready_i;
  assign load_c      = ~gnt_valid_q | handshake_c;
  assign ptr_inc_c   = IDX_W'(ptr_wrap_inc(32'(gnt_idx_q), REQ_NUM));
  // Back-to-back grants search from the already-advanced pointer.
  assign pick_ptr_c  = handshake_c ? ptr_inc_c : ptr_q;

  rr_priority_pick #(
    .REQ_NUM (REQ_NUM),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i     (req_i),
    .ptr_i     (pick_ptr_c),
    .found_c_o (found_c),
    .idx_c_o   (cand_idx_c)
  );

  always_comb begin
    gnt_valid_d = gnt_valid_q;
    gnt_idx_d   = gnt_idx_q;
    ptr_d       = ptr_q;
    if (handshake_c) ptr_d = ptr_inc_c;
    if (load_c) begin
      gnt_valid_d = found_c;
      if (found_c) gnt_idx_d = cand_idx_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_valid_q <= 1'b0;
      gnt_idx_q   <= '0;
      ptr_q       <= '0;
    end else begin
      gnt_valid_q <= gnt_valid_d;
      gnt_idx_q   <= gnt_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign gnt_valid_o = gnt_valid_q;
  assign gnt_idx_o   = gnt_idx_q;

`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
  logic [REQ_NUM-1:0] dec_c;

  onehot_decoder #(
    .INPUT_W  (IDX_W),
    .OUTPUT_W (REQ_NUM)
  ) u_dec (
    .in_i  (gnt_idx_q),
    .out_o (dec_c)
  );

  assign gnt_onehot_o = dec_c & {REQ_NUM{gnt_valid_q}};
`endif

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Randomized and directed checks of rr_arbiter_enc (8 and 5 requesters) against a rotation model.
module tb_rr_arbiter_enc;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req8 = '0;
  logic       rdy8 = 1'b0;
  logic       v8;
  logic [2:0] idx8;
  logic [4:0] req5 = '0;
  logic       rdy5 = 1'b0;
  logic       v5;
  logic [2:0] idx5;
`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
  logic [7:0] oh8;
  logic [4:0] oh5;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: grant valid, granted index, rotation pointer.
  bit m_v8 = 0, m_v5 = 0;
  int m_i8 = 0, m_i5 = 0, m_p8 = 0, m_p5 = 0;

  always #5 clk = ~clk;

  rr_arbiter_enc #(.REQ_NUM(8)) dut8 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req8),
    .gnt_valid_o (v8),
    .gnt_ready_i (rdy8),
    .gnt_idx_o   (idx8)
`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
    ,
    .gnt_onehot_o(oh8)
`endif
  );

  rr_arbiter_enc #(.REQ_NUM(5)) dut5 (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req5),
    .gnt_valid_o (v5),
    .gnt_ready_i (rdy5),
    .gnt_idx_o   (idx5)
`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
    ,
    .gnt_onehot_o(oh5)
`endif
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock of the arbitration rules for an n-requester arbiter.
  task automatic model_next(input int n, input bit [7:0] req, input bit rdy,
                            inout bit v, inout int idx, inout int ptr);
    if (v && rdy) ptr = (idx + 1) % n;
    if (!v || rdy) begin
      v = 0;
      for (int k = 0; k < n; k++) begin
        if (!v && req[(ptr + k) % n]) begin
          v   = 1;
          idx = (ptr + k) % n;
        end
      end
    end
  endtask

  task automatic model_reset();
    m_v8 = 0; m_i8 = 0; m_p8 = 0;
    m_v5 = 0; m_i5 = 0; m_p5 = 0;
  endtask

  task automatic check_outputs(input string tag);
    check_eq({tag, "_v8"}, int'(v8), int'(m_v8));
    check_eq({tag, "_idx8"}, int'(idx8), m_i8);
    check_eq({tag, "_v5"}, int'(v5), int'(m_v5));
    check_eq({tag, "_idx5"}, int'(idx5), m_i5);
    check_eq({tag, "_rng5"}, int'(idx5 < 3'd5), 1);
`ifdef RR_ARBITER_ENC_ONEHOT_OUT_EN
    check_eq({tag, "_oh8"}, int'(oh8), m_v8 ? (1 << m_i8) : 0);
    check_eq({tag, "_oh5"}, int'(oh5), m_v5 ? (1 << m_i5) : 0);
`endif
  endtask

  // Called at a negedge: drive, advance model, check after the rising edge.
  task automatic cycle(input string tag, input bit [7:0] r8, input bit y8,
                       input bit [4:0] r5, input bit y5);
    req8 = r8; rdy8 = y8; req5 = r5; rdy5 = y5;
    model_next(8, r8, y8, m_v8, m_i8, m_p8);
    model_next(5, {3'b000, r5}, y5, m_v5, m_i5, m_p5);
    @(posedge clk);
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with every request active.
    rst = 1'b1; req8 = 8'hFF; req5 = 5'h1F;
    repeat (3) @(negedge clk);
    model_reset();
    check_outputs("reset");
    rst = 1'b0;
    cycle("first", 8'hFF, 1'b0, 5'h1F, 1'b1);
    check_eq("first_idx0", int'(idx8), 0);

    // Rotation over a sparse pattern, one grant per cycle.
    cycle("rot", 8'hA5, 1'b1, 5'h1F, 1'b1);
    for (int i = 0; i < 10; i++) cycle("rot", 8'hA5, 1'b1, 5'h1F, 1'b1);

    // Backpressure: grant 3 frozen while its request drops and req[1] rises.
    rst = 1'b1; #1; rst = 1'b0; model_reset();
    cycle("bp_get3", 8'h08, 1'b0, 5'h1F, 1'b1);
    check_eq("bp_idx3", int'(idx8), 3);
    for (int i = 0; i < 4; i++) cycle("bp_hold", 8'h02, 1'b0, 5'h1F, 1'b1);
    cycle("bp_rel", 8'h02, 1'b1, 5'h1F, 1'b1);
    check_eq("bp_next1", int'(idx8), 1);

    // Idle, then a single-cycle pulse on req[6].
    cycle("drain", 8'h00, 1'b1, 5'h00, 1'b1);
    for (int i = 0; i < 4; i++) cycle("idle", 8'h00, 1'($urandom_range(0, 1)), 5'h00, 1'b1);
    cycle("pulse", 8'h40, 1'b0, 5'h00, 1'b1);
    check_eq("pulse_idx6", int'(idx8), 6);
    cycle("pulse_hold", 8'h00, 1'b0, 5'h00, 1'b1);
    cycle("pulse_done", 8'h00, 1'b1, 5'h00, 1'b1);
    cycle("pulse_gone", 8'h00, 1'b1, 5'h00, 1'b1);

    // Asynchronous reset while grant 4 is pending.
    cycle("ar_get4", 8'h10, 1'b0, 5'h10, 1'b0);
    check_eq("ar_idx4", int'(idx8), 4);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_async_v8", int'(v8), 0);
    check_eq("ar_async_v5", int'(v5), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle("ar_restart", 8'hFF, 1'b1, 5'h1F, 1'b1);
    check_eq("ar_restart_idx0", int'(idx8), 0);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 600; i++) begin
      bit [7:0] r8;
      bit [4:0] r5;
      r8 = 8'($urandom) & ((i % 3 == 0) ? 8'($urandom) : 8'hFF);
      r5 = 5'($urandom);
      cycle("rand", r8, 1'($urandom_range(0, 3) != 0), r5, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
